apu_frame_sequencer: RTL and testbench
======================================

Name: apu_frame_sequencer

Overview:
- APU frame counter: generates the quarter_frame / half_frame strobes that clock the envelope, sweep and length-counter units, and raises the frame IRQ.
- Sits in the APU beside the channel units. Driven by the CPU-rate enable and by the $4017 write and $4015 read strobes from the APU register decoder.
- Supports 4-step and 5-step sequence modes.

Parameters:
- CNT_W, 16, width of the cycle counter
- STEP1, 7457, CPU-cycle count of step 1
- STEP2, 14913, CPU-cycle count of step 2
- STEP3, 22371, CPU-cycle count of step 3
- STEP4, 29829, CPU-cycle count of step 4 (4-step wrap point)
- STEP5, 37281, CPU-cycle count of step 5 (5-step wrap point)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- cpu_en  input  1  CPU-cycle enable; all state advances only when high
- reg_write  input  1  write strobe to $4017, qualified by cpu_en
- reg_wdata  input  8  write data; bit7 = mode (1 = 5-step), bit6 = IRQ inhibit
- status_read  input  1  read strobe of $4015, qualified by cpu_en; clears the frame IRQ
- quarter_frame  output  1  quarter-frame strobe; consumers qualify it with cpu_en
- half_frame  output  1  half-frame strobe; consumers qualify it with cpu_en
- frame_irq  output  1  frame interrupt flag, level
- mode  output  1  current sequence mode

Behaviour:
- Reset (async): cnt = 0, mode = 0, inhibit = 0, frame_irq = 0, pending = 0, delay = 0, parity = 0, force = 0.
  - All outputs are 0 during and after reset until the first step.
  - Reset asserted mid-delay cancels the pending reload.
- State changes only on clk edges where cpu_en = 1.
  - parity toggles on every such edge.
- Counter: cnt increments by 1 per cpu_en.
  - Mode 0: wraps to 0 on the cpu_en following cnt == STEP4.
  - Mode 1: wraps to 0 on the cpu_en following cnt == STEP5.
- Step decode (combinational from cnt and mode; high for exactly one cpu_en period):
  - Mode 0: quarter at STEP1, STEP2, STEP3, STEP4; half at STEP2, STEP4.
  - Mode 1: quarter at STEP1, STEP2, STEP3, STEP5; half at STEP2, STEP5. cnt == STEP4 produces nothing.
- quarter_frame = decode_q | force; half_frame = decode_h | force.
- IRQ:
  - Set on cpu_en when mode = 0, inhibit = 0 and cnt is STEP4-1 or STEP4.
  - Cleared on cpu_en & status_read; a simultaneous set wins.
  - Cleared when a write sets inhibit = 1.
  - Never set in mode 1.
- Write (cpu_en & reg_write):
  - mode and inhibit update immediately from reg_wdata[7:6].
  - pending is set and the delay is loaded (see Optional Feature).
  - A write while pending reloads the delay, so the last write wins.
- Pending reload:
  - delay decrements on each cpu_en.
  - On the cpu_en where delay == 1: cnt is set to 0, pending is cleared, force is set to the current mode.
  - force clears on the next cpu_en, so in mode 1 the quarter_frame and half_frame strobes are present during the cpu_en period where cnt == 0.
- Reload takes priority over the normal increment and wrap on the same edge.
- mode output reflects the register value.

Optional Feature:
- Macro: APU_FRAME_WRITE_JITTER_EN
- Defined: the reload delay depends on write alignment. It is loaded with 3 when parity = 0 at the write edge and 4 when parity = 1, modelling the APU half-cycle alignment.
- Undefined: the delay is always loaded with 3 and parity logic is omitted.

Test Plan:
- Reset, free-run mode 0 → quarter pulses at cnt 7457, 14913, 22371, 29829; half at 14913, 29829; frame_irq rises at cnt 29828; cnt returns to 0 after 29829; period is 29830 cpu_en.
- Write 0x80, then run → after the delay, one forced quarter+half at cnt 0; steps at 7457/14913/22371/37281, none at 29829; period 37282; frame_irq stays 0.
- Mode 0 with frame_irq = 1, status_read pulse → frame_irq = 0 next edge. status_read coincident with cnt = 29829 → frame_irq stays 1.
- Write 0x40 while frame_irq = 1 → frame_irq = 0 immediately; no IRQ on later passes through 29828/29829.
- Two writes 2 cycles apart → a single reload, timed from the second write (delay 3; with APU_FRAME_WRITE_JITTER_EN, 3 or 4 depending on parity). Async reset asserted mid-delay → no reload and no force pulse.
- cpu_en held low for 10 clk → cnt, outputs and flags frozen.

Source files
------------

// File: rtl/apu_frame_sequencer.sv
// APU frame counter: quarter/half-frame strobes and frame IRQ for 4-step and 5-step sequences.
// Optional macro APU_FRAME_WRITE_JITTER_EN makes the $4017 reload delay depend on write parity.
module apu_frame_sequencer #(
    parameter int CNT_W = 16,
    parameter int STEP1 = 7457,
    parameter int STEP2 = 14913,
    parameter int STEP3 = 22371,
    parameter int STEP4 = 29829,
    parameter int STEP5 = 37281
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_en,
    input  logic       reg_write,
    input  logic [7:0] reg_wdata,
    input  logic       status_read,
    output logic       quarter_frame,
    output logic       half_frame,
    output logic       frame_irq,
    output logic       mode
);

    localparam logic [CNT_W-1:0] S1   = CNT_W'(STEP1);
    localparam logic [CNT_W-1:0] S2   = CNT_W'(STEP2);
    localparam logic [CNT_W-1:0] S3   = CNT_W'(STEP3);
    localparam logic [CNT_W-1:0] S4   = CNT_W'(STEP4);
    localparam logic [CNT_W-1:0] S4M1 = CNT_W'(STEP4 - 1);
    localparam logic [CNT_W-1:0] S5   = CNT_W'(STEP5);

    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             mode_q, mode_nxt;
    logic             inhibit, inhibit_nxt;
    logic             irq_q, irq_nxt;
    logic             pending, pending_nxt;
    logic [2:0]       delay, delay_nxt;
    logic             frc, frc_nxt;
    logic [2:0]       load_val;
    logic             dec_q, dec_h;
    logic             at_wrap, irq_set;

    logic unused_wdata;
    assign unused_wdata = ^reg_wdata[5:0];

`ifdef APU_FRAME_WRITE_JITTER_EN
    logic parity;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       parity <= 1'b0;
        else if (cpu_en) parity <= ~parity;
    end

    // A write landing on an odd CPU cycle waits one extra cycle for the APU half-cycle.
    assign load_val = parity ? 3'd4 : 3'd3;
`else
    assign load_val = 3'd3;
`endif

    always_comb begin
        dec_q = 1'b0;
        dec_h = 1'b0;
        if (cnt == S1 || cnt == S3) dec_q = 1'b1;
        if (cnt == S2) begin
            dec_q = 1'b1;
            dec_h = 1'b1;
        end
        // STEP4 is silent in 5-step mode; the sequence ends at STEP5 instead.
        if ((!mode_q && cnt == S4) || (mode_q && cnt == S5)) begin
            dec_q = 1'b1;
            dec_h = 1'b1;
        end
    end

    // >= also catches a 1->0 mode switch made after the count passed STEP4.
    assign at_wrap = mode_q ? (cnt >= S5) : (cnt >= S4);
    assign irq_set = !mode_q && !inhibit && (cnt == S4M1 || cnt == S4);

    always_comb begin
        cnt_nxt     = cnt;
        mode_nxt    = mode_q;
        inhibit_nxt = inhibit;
        irq_nxt     = irq_q;
        pending_nxt = pending;
        delay_nxt   = delay;
        frc_nxt     = frc;
        if (cpu_en) begin
            frc_nxt = 1'b0;
            cnt_nxt = at_wrap ? '0 : cnt + CNT_W'(1);
            if (status_read) irq_nxt = 1'b0;
            if (irq_set)     irq_nxt = 1'b1;
            if (reg_write) begin
                // A new write restarts the delay; any reload already in flight is dropped.
                mode_nxt    = reg_wdata[7];
                inhibit_nxt = reg_wdata[6];
                pending_nxt = 1'b1;
                delay_nxt   = load_val;
                if (reg_wdata[6]) irq_nxt = 1'b0;
            end else if (pending) begin
                delay_nxt = delay - 3'd1;
                if (delay == 3'd1) begin
                    cnt_nxt     = '0;
                    pending_nxt = 1'b0;
                    frc_nxt     = mode_q;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            mode_q  <= 1'b0;
            inhibit <= 1'b0;
            irq_q   <= 1'b0;
            pending <= 1'b0;
            delay   <= 3'd0;
            frc     <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            mode_q  <= mode_nxt;
            inhibit <= inhibit_nxt;
            irq_q   <= irq_nxt;
            pending <= pending_nxt;
            delay   <= delay_nxt;
            frc     <= frc_nxt;
        end
    end

    assign quarter_frame = dec_q | frc;
    assign half_frame    = dec_h | frc;
    assign frame_irq     = irq_q;
    assign mode          = mode_q;

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Scoreboard bench for apu_frame_sequencer with shortened step counts (20/40/60/80/100).
module tb_apu_frame_sequencer;

    localparam int S1 = 20, S2 = 40, S3 = 60, S4 = 80, S5 = 100;

    logic       clk = 1'b0;
    logic       reset, cpu_en, reg_write, status_read;
    logic [7:0] reg_wdata;
    logic       quarter_frame, half_frame, frame_irq, mode;

    int total = 0;
    int bad   = 0;
    int tick;

    typedef struct {
        int   t;
        logic q;
        logic h;
        logic irq;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;

    always #5 clk = ~clk;

    apu_frame_sequencer #(
        .CNT_W(16), .STEP1(S1), .STEP2(S2), .STEP3(S3), .STEP4(S4), .STEP5(S5)
    ) dut (
        .clk(clk), .reset(reset), .cpu_en(cpu_en), .reg_write(reg_write),
        .reg_wdata(reg_wdata), .status_read(status_read),
        .quarter_frame(quarter_frame), .half_frame(half_frame),
        .frame_irq(frame_irq), .mode(mode)
    );

    // Bench time base: number of cpu_en edges since reset; the DUT count equals it until a reload.
    always @(posedge clk or posedge reset) begin
        if (reset)       tick <= 0;
        else if (cpu_en) tick <= tick + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (tick %0d)", name, act, exp, tick);
        end
    endtask

    task automatic push(input int t, input logic q, input logic h, input logic irq);
        exp_q.push_back('{t, q, h, irq});
    endtask

    function automatic int dly(input int t);
`ifdef APU_FRAME_WRITE_JITTER_EN
        return (t % 2 == 1) ? 4 : 3;
`else
        return 3;
`endif
    endfunction

    // Monitor: every strobe seen on a cpu_en cycle must match the head of the queue.
    always @(negedge clk) begin
        if (!reset && cpu_en && (quarter_frame || half_frame)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe: tick=%0d q=%b h=%b irq=%b, queue empty",
                         tick, quarter_frame, half_frame, frame_irq);
            end else begin
                mon_e = exp_q.pop_front();
                if (tick != mon_e.t || quarter_frame !== mon_e.q || half_frame !== mon_e.h ||
                    frame_irq !== mon_e.irq) begin
                    bad++;
                    $display("FAIL strobe: got tick=%0d q=%b h=%b irq=%b expected tick=%0d q=%b h=%b irq=%b",
                             tick, quarter_frame, half_frame, frame_irq,
                             mon_e.t, mon_e.q, mon_e.h, mon_e.irq);
                end
            end
        end
    end

    task automatic goto(input int t);
        int n;
        n = 0;
        while (tick != t && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (tick != t) begin
            total++;
            bad++;
            $display("FAIL goto: tick=%0d expected %0d", tick, t);
        end
    endtask

    task automatic write_reg(input logic [7:0] d);
        reg_write = 1'b1;
        reg_wdata = d;
        @(posedge clk); #1;
        reg_write = 1'b0;
    endtask

    task automatic sread();
        status_read = 1'b1;
        @(posedge clk); #1;
        status_read = 1'b0;
    endtask

    initial begin
        int base, w, r, t1, e;
        reset = 1'b1; cpu_en = 1'b1; reg_write = 1'b0; reg_wdata = 8'h00; status_read = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_q", quarter_frame, 0);
        check("rst_h", half_frame, 0);
        check("rst_irq", frame_irq, 0);
        check("rst_mode", mode, 0);
        reset = 1'b0;
        check("post_rst_q", quarter_frame, 0);
        check("post_rst_h", half_frame, 0);

        // 4-step free run, two passes (period 81)
        push(20, 1, 0, 0);  push(40, 1, 1, 0);  push(60, 1, 0, 0);  push(80, 1, 1, 1);
        push(101, 1, 0, 0); push(121, 1, 1, 0); push(141, 1, 0, 0); push(161, 1, 1, 1);
        goto(79);
        check("irq_before_s4m1", frame_irq, 0);
        goto(80);
        sread();
        check("irq_read_coincident", frame_irq, 1);
        sread();
        check("irq_read_clear", frame_irq, 0);
        check("mode0", mode, 0);

        // inhibit write clears IRQ and suppresses later sets
        goto(162);
        check("irq_before_inhibit", frame_irq, 1);
        write_reg(8'h40);
        check("irq_inhibit_clear", frame_irq, 0);
        base = 162 + dly(162) + 1;
        push(base + 20, 1, 0, 0); push(base + 40, 1, 1, 0);
        push(base + 60, 1, 0, 0); push(base + 80, 1, 1, 0);
        goto(base + 79);
        check("irq_inhibited_s4m1", frame_irq, 0);
        goto(base + 81);
        check("irq_inhibited_wrap", frame_irq, 0);

        // switch to 5-step: forced strobe at cnt 0, nothing at STEP4, period 101
        w = base + 81;
        write_reg(8'h80);
        check("mode1", mode, 1);
        r = w + dly(w) + 1;
        push(r, 1, 1, 0);        push(r + 20, 1, 0, 0);  push(r + 40, 1, 1, 0);
        push(r + 60, 1, 0, 0);   push(r + 100, 1, 1, 0); push(r + 121, 1, 0, 0);
        push(r + 141, 1, 1, 0);  push(r + 161, 1, 0, 0);
        goto(r + 80);
        check("irq_mode1_s4", frame_irq, 0);
        goto(r + 101);
        check("irq_mode1_wrap", frame_irq, 0);

        // cpu_en low for 10 clocks: state frozen, unqualified write ignored
        goto(r + 141);
        cpu_en = 1'b0;
        reg_write = 1'b1;
        reg_wdata = 8'h00;
        repeat (10) begin @(posedge clk); #1; end
        check("freeze_q", quarter_frame, 1);
        check("freeze_h", half_frame, 1);
        check("freeze_mode", mode, 1);
        check("freeze_irq", frame_irq, 0);
        reg_write = 1'b0;
        cpu_en = 1'b1;

        // two writes two cycles apart: a single reload timed from the second
        t1 = r + 170;
        goto(t1);
        write_reg(8'h80);
        @(posedge clk); #1;
        write_reg(8'h80);
        e = t1 + 2 + dly(t1 + 2) + 1;
        push(e, 1, 1, 0); push(e + 20, 1, 0, 0);

        // reset in the middle of a reload delay cancels it
        goto(e + 25);
        write_reg(8'h80);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_mode", mode, 0);
        check("mid_rst_q", quarter_frame, 0);
        push(20, 1, 0, 0); push(40, 1, 1, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rel_q", quarter_frame, 0);
        check("rel_h", half_frame, 0);
        goto(41);
        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
